// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter (pipeline port A, loader/debug port B)
// One transaction in flight; ties alternate, and a BUSY timeout completes the access with an error.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ack_o,
    output logic              a_err_o,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic              a_stall_o,

    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic              b_err_o,
    output logic [DATA_W-1:0] b_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    localparam logic       OWN_A    = 1'b0;
    localparam logic       OWN_B    = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_A;
            last_grant_q <= OWN_B;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        grant        = OWN_A;

        unique case (state_q)
            ST_IDLE: begin
                if (a_req_i || b_req_i) begin
                    // On a tie the port that did not win last time gets the memory.
                    if (a_req_i && b_req_i) begin
                        grant = (last_grant_q == OWN_A) ? OWN_B : OWN_A;
                    end else begin
                        grant = b_req_i ? OWN_B : OWN_A;
                    end
                    owner_d      = grant;
                    last_grant_d = grant;
                    we_d         = (grant == OWN_B) ? b_we_i    : a_we_i;
                    addr_d       = (grant == OWN_B) ? b_addr_i  : a_addr_i;
                    wdata_d      = (grant == OWN_B) ? b_wdata_i : a_wdata_i;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_B) b_rdata_d = mem_rdata_i;
                        else                  a_rdata_d = mem_rdata_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                    if (owner_q == OWN_B) b_rdata_d = '0;
                    else                  a_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req_o   = (state_q == ST_BUSY);
    assign mem_we_o    = (state_q == ST_BUSY) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign a_ack_o   = (state_q == ST_RESP) && (owner_q == OWN_A);
    assign b_ack_o   = (state_q == ST_RESP) && (owner_q == OWN_B);
    assign a_err_o   = a_ack_o && err_q;
    assign b_err_o   = b_ack_o && err_q;
    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;
    assign a_stall_o = a_req_i && !a_ack_o;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both ports and the memory side.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter TIMEOUT, default 16, maximum BUSY cycles to wait for mem_ack_i; legal range 2..255.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 a_req_i / a_we_i  input  1 each  pipeline MEM-stage request and write-enable (port A).
REQ-007 a_addr_i / a_wdata_i  input  ADDR_W / DATA_W  port A address and write data.
REQ-008 a_ack_o / a_err_o  output  1 each  port A completion pulse and timeout flag.
REQ-009 a_rdata_o  output  DATA_W  port A read data.
REQ-010 a_stall_o  output  1  pipeline stall: a_req_i high and port A not being acked this cycle (combinational).
REQ-011 b_req_i, b_we_i, b_addr_i, b_wdata_i, b_ack_o, b_err_o, b_rdata_o: loader/debug port B, same widths and meanings as port A.
REQ-012 mem_req_o / mem_we_o  output  1 each  data-memory request and write-enable.
REQ-013 mem_addr_o / mem_wdata_o  output  ADDR_W / DATA_W  registered memory address and write data.
REQ-014 mem_ack_i  input  1  memory completion; mem_rdata_i  input  DATA_W  read data, valid when mem_ack_i is high.

Function
REQ-015 FSM states: IDLE, BUSY, RESP; one transaction in flight at most.
REQ-016 Requester protocol: req held high with addr/we/wdata stable until ack; each ack completes exactly one transaction.
REQ-017 IDLE: samples requests at each edge; if any is pending, latch owner, we, addr, wdata into registers and go to BUSY.
REQ-018 Arbitration: single request is granted; when both request, grant the port not in last_grant; update last_grant on every grant.
REQ-019 BUSY: mem_req_o=1, mem_we_o/addr/wdata from latched values; held constant until exit.
REQ-020 BUSY with mem_ack_i=1: capture mem_rdata_i into owner's rdata (reads only; writes leave rdata unchanged), go to RESP.
REQ-021 BUSY timeout counter: cleared on entry and increments each BUSY cycle without mem_ack_i; at TIMEOUT such cycles go to RESP with error, owner's rdata set to 0.
REQ-022 RESP: lasts exactly one cycle; owner's ack_o=1; err_o=1 only if entered via timeout; then to IDLE; requests not sampled in RESP.
REQ-023 Latency: zero-wait memory gives req sampled at edge N -> mem_req_o high in cycle N+1 -> ack_o high in cycle N+2.
REQ-024 mem_ack_i in IDLE or RESP is ignored.
REQ-025 Non-owner ack_o/err_o stay 0; x_rdata_o holds its value until that port's next completed read.
REQ-026 Back-to-back: a requester keeping req high after ack is treated as a new transaction sampled in the following IDLE cycle.

Reset
REQ-027 rst_i=1 forces immediately, independent of clk_i: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, both ack_o=0, err_o=0, rdata_o=0, timeout counter 0, last_grant=B (port A wins the first tie).
REQ-028 Reset during BUSY abandons the transaction; no ack is issued for it after reset release.
REQ-029 First request sampling occurs at the first rising edge after rst_i deasserts.

Verification
REQ-030 Port A read alone, addr 0x10, memory acks in first BUSY cycle with 0xDEADBEEF -> a_ack_o pulses 2 cycles after sampling, a_rdata_o=0xDEADBEEF, a_err_o=0, a_stall_o high until the ack cycle.
REQ-031 A and B request together after reset -> A granted first, then B; a second tie -> B granted first; alternation continues.
REQ-032 Port B write, addr 0x20, data 0x12345678, mem_ack_i after 3 wait cycles -> mem_we_o=1 and stable for 4 BUSY cycles, b_ack_o one pulse, b_rdata_o unchanged.
REQ-033 mem_ack_i never asserted, TIMEOUT=16 -> exactly 16 BUSY cycles, then owner ack_o=1 and err_o=1, rdata_o=0, FSM in IDLE next cycle.
REQ-034 rst_i pulsed mid-BUSY between edges -> mem_req_o drops before the next edge, no ack issued afterwards, next tie grants A.
REQ-035 Spurious mem_ack_i in IDLE with no requests -> no state change, no ack, no rdata update.
